// File: rtl/ca3_attractor_memory.sv
// Hebbian attractor memory gated by a theta phase reference: learns patterns on theta peaks,
// recalls by iterative settling on troughs, and slowly forgets weights after idle troughs.
module ca3_attractor_memory #(
    parameter int WIDTH          = 18,
    parameter int FRAC           = 14,
    parameter int N_UNITS        = 6,
    parameter int WEIGHT_W       = 8,
    parameter int LEARN_RATE     = 2,
    parameter int WEIGHT_MAX     = 100,
    parameter int DECAY_RATE     = 1,
    parameter int DECAY_INTERVAL = 10,
    parameter int RECALL_ITERS   = 4,
    parameter int THETA_THR      = 12288,
    parameter int THETA_HYST     = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en_i,
    input  logic signed [WIDTH-1:0] theta_x_i,
    input  logic [N_UNITS-1:0]      pattern_in_i,
    input  logic                    clear_i,
    output logic [N_UNITS-1:0]      phase_pattern_o,
    output logic                    learning_o,
    output logic                    recalling_o,
    output logic                    decaying_o,
    output logic                    settled_o,
    output logic [3:0]              debug_state_o
);

    localparam int IW    = $clog2(N_UNITS);
    localparam int ACC_W = WEIGHT_W + $clog2(N_UNITS) + 1;
    localparam int TW    = 16;

    localparam logic signed [WIDTH-1:0] ThrHi     = WIDTH'(THETA_THR);
    localparam logic signed [WIDTH-1:0] ThrLo     = WIDTH'(-THETA_THR);
    localparam logic signed [WIDTH-1:0] LearnExit = WIDTH'(THETA_THR - THETA_HYST);
    localparam logic signed [WIDTH-1:0] TroughExit = WIDTH'(-THETA_THR + THETA_HYST);
    localparam logic [IW-1:0] LastIdx   = IW'(N_UNITS - 1);
    localparam logic [IW-1:0] PenIdx    = IW'(N_UNITS - 2);
    localparam logic [3:0]    LastPass  = 4'(RECALL_ITERS - 1);
    localparam logic [TW-1:0] TroughLim = TW'(DECAY_INTERVAL);

    if (N_UNITS < 2 || N_UNITS > 16) begin : g_chk_units
        $error("N_UNITS must be within 2..16");
    end
    if (RECALL_ITERS < 1 || RECALL_ITERS > 15) begin : g_chk_iters
        $error("RECALL_ITERS must be within 1..15");
    end
    if (WEIGHT_MAX >= (1 << (WEIGHT_W - 1))) begin : g_chk_wmax
        $error("WEIGHT_MAX must fit in WEIGHT_W signed bits");
    end
    if (FRAC >= WIDTH) begin : g_chk_frac
        $error("FRAC must be below WIDTH");
    end

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StLearn      = 4'd1,
        StLearnDone  = 4'd2,
        StRecallAcc  = 4'd3,
        StRecallUpd  = 4'd4,
        StRecallDone = 4'd5,
        StDecay      = 4'd6,
        StDecayDone  = 4'd7,
        StClear      = 4'd8
    } state_e;

    state_e state_q, state_d;

    logic signed [WEIGHT_W-1:0] w_q [N_UNITS][N_UNITS];
    logic signed [ACC_W-1:0]    acc_q [N_UNITS];
    logic signed [ACC_W-1:0]    acc_d [N_UNITS];
    logic [N_UNITS-1:0]         s_q, s_d, pp_q;
    logic [IW-1:0]              pi_q, pj_q, col_q;
    logic [3:0]                 pass_q;
    logic [TW-1:0]              trough_q;
    logic                       arm_q, settled_q;
    logic signed [WEIGHT_W-1:0] pair_w_d;

    logic theta_hi, theta_lo, pat_nz, last_pair, converged, last_pass;

    assign theta_hi  = theta_x_i > ThrHi;
    assign theta_lo  = theta_x_i < ThrLo;
    assign pat_nz    = |pattern_in_i;
    assign last_pair = (pi_q == PenIdx) && (pj_q == LastIdx);
    assign converged = (s_d == s_q);
    assign last_pass = (pass_q == LastPass);

    // Shared pair datapath: decay shrinks magnitude toward zero, learning adds a saturating step.
    always_comb begin : pair_update
        int sum;
        sum = int'(w_q[pi_q][pj_q]);
        if (state_q == StDecay) begin
            if (sum > 0) sum = (sum > DECAY_RATE) ? sum - DECAY_RATE : 0;
            else if (sum < 0) sum = (sum < -DECAY_RATE) ? sum + DECAY_RATE : 0;
        end else begin
            sum = (pattern_in_i[pi_q] == pattern_in_i[pj_q]) ? sum + LEARN_RATE
                                                             : sum - LEARN_RATE;
            if (sum > WEIGHT_MAX) sum = WEIGHT_MAX;
            else if (sum < -WEIGHT_MAX) sum = -WEIGHT_MAX;
        end
        pair_w_d = WEIGHT_W'(sum);
    end

    always_comb begin : recall_math
        s_d = s_q;
        for (int i = 0; i < N_UNITS; i++) begin
            acc_d[i] = s_q[col_q] ? acc_q[i] + ACC_W'(w_q[i][col_q])
                                  : acc_q[i] - ACC_W'(w_q[i][col_q]);
            if (acc_q[i][ACC_W-1]) s_d[i] = 1'b0;
            else if (acc_q[i] != '0) s_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else if (clk_en_i) state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (clear_i) begin
            state_d = StClear;
        end else begin
            case (state_q)
                StIdle: begin
                    if (theta_hi && pat_nz) state_d = StLearn;
                    else if (theta_lo && pat_nz) state_d = StRecallAcc;
                    else if (theta_lo && trough_q >= TroughLim) state_d = StDecay;
                end
                StLearn:      if (last_pair) state_d = StLearnDone;
                StLearnDone:  if (theta_x_i < LearnExit) state_d = StIdle;
                StRecallAcc:  if (col_q == LastIdx) state_d = StRecallUpd;
                StRecallUpd:  state_d = (converged || last_pass) ? StRecallDone : StRecallAcc;
                StRecallDone: if (theta_x_i > TroughExit) state_d = StIdle;
                StDecay:      if (last_pair) state_d = StDecayDone;
                StDecayDone:  if (theta_x_i > TroughExit) state_d = StIdle;
                default:      state_d = StIdle;
            endcase
        end
    end

    always_comb begin : outputs
        learning_o      = (state_q == StLearn);
        recalling_o     = (state_q == StRecallAcc) || (state_q == StRecallUpd);
        decaying_o      = (state_q == StDecay);
        settled_o       = settled_q;
        phase_pattern_o = pp_q;
        debug_state_o   = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_UNITS; i++) begin
                acc_q[i] <= '0;
                for (int j = 0; j < N_UNITS; j++) w_q[i][j] <= '0;
            end
            s_q       <= '0;
            pp_q      <= '0;
            pi_q      <= '0;
            pj_q      <= IW'(1);
            col_q     <= '0;
            pass_q    <= '0;
            trough_q  <= '0;
            arm_q     <= 1'b1;
            settled_q <= 1'b0;
        end else if (clk_en_i) begin
            // Troughs only count after a peak has re-armed the edge detector.
            if (theta_hi) begin
                arm_q <= 1'b1;
            end else if (theta_lo) begin
                arm_q <= 1'b0;
                if (arm_q && !pat_nz && trough_q < TroughLim) trough_q <= trough_q + 1'b1;
            end
            if (state_q == StDecayDone && state_d == StIdle) trough_q <= '0;

            if (state_q == StLearn || state_q == StDecay) begin
                w_q[pi_q][pj_q] <= pair_w_d;
                w_q[pj_q][pi_q] <= pair_w_d;
                if (pj_q == LastIdx) begin
                    pi_q <= pi_q + 1'b1;
                    pj_q <= pi_q + IW'(2);
                end else begin
                    pj_q <= pj_q + 1'b1;
                end
            end else begin
                pi_q <= '0;
                pj_q <= IW'(1);
            end

            if (state_q == StClear) begin
                for (int i = 0; i < N_UNITS; i++)
                    for (int j = 0; j < N_UNITS; j++) w_q[i][j] <= '0;
            end

            case (state_q)
                StIdle: begin
                    if (state_d == StRecallAcc) begin
                        s_q    <= pattern_in_i;
                        pass_q <= '0;
                        col_q  <= '0;
                        for (int i = 0; i < N_UNITS; i++) acc_q[i] <= '0;
                    end
                end
                StRecallAcc: begin
                    for (int i = 0; i < N_UNITS; i++) acc_q[i] <= acc_d[i];
                    col_q <= col_q + 1'b1;
                end
                StRecallUpd: begin
                    s_q    <= s_d;
                    pp_q   <= s_d;
                    col_q  <= '0;
                    pass_q <= pass_q + 1'b1;
                    for (int i = 0; i < N_UNITS; i++) acc_q[i] <= '0;
                    if (converged || last_pass) settled_q <= converged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ca3_attractor_memory.sv
// Scoreboard bench for ca3_attractor_memory: stimulus queues expectations keyed to DUT events,
// a monitor pops and compares them when those events appear.
module tb_ca3_attractor_memory;

    localparam int EvLearnDone  = 1;
    localparam int EvRecallUpd  = 2;
    localparam int EvRecallDone = 3;
    localparam int EvDecayDone  = 4;
    localparam int EvProbe      = 5;

    localparam int KState   = 0;
    localparam int KPp      = 1;
    localparam int KFlags   = 2;
    localparam int KW       = 3;
    localparam int KAcc     = 4;
    localparam int KLcnt    = 5;
    localparam int KDcnt    = 6;
    localparam int KTrough  = 7;
    localparam int KSettled = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b1;
    logic              clear = 1'b0;
    logic signed [17:0] theta = '0;
    logic [5:0]        pat = '0;
    logic [5:0]        pp;
    logic              learning, recalling, decaying, settled;
    logic [3:0]        dstate;

    ca3_attractor_memory dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en_i       (clk_en),
        .theta_x_i      (theta),
        .pattern_in_i   (pat),
        .clear_i        (clear),
        .phase_pattern_o(pp),
        .learning_o     (learning),
        .recalling_o    (recalling),
        .decaying_o     (decaying),
        .settled_o      (settled),
        .debug_state_o  (dstate)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    ev;
        int    grp;
        int    kind;
        int    a;
        int    b;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int applied = 0;
    int miscompares = 0;
    int grp_id = 0;
    int probe_cnt = 0;
    int lcnt = 0;
    int dcnt = 0;

    task automatic new_group();
        grp_id++;
    endtask

    task automatic expect_v(input int ev, input int kind, input int a, input int b,
                            input int exp, input string name);
        exp_t e;
        e.ev = ev; e.grp = grp_id; e.kind = kind; e.a = a; e.b = b; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    function automatic int actual(input int kind, input int a, input int b);
        logic [2:0] ia, ib;
        ia = a[2:0];
        ib = b[2:0];
        case (kind)
            KState:   return int'(dstate);
            KPp:      return int'(pp);
            KFlags:   return int'({learning, recalling, decaying, settled});
            KW:       return int'(dut.w_q[ia][ib]);
            KAcc:     return int'(dut.acc_q[ia]);
            KLcnt:    return lcnt;
            KDcnt:    return dcnt;
            KTrough:  return int'(dut.trough_q);
            KSettled: return int'(settled);
            default:  return -999999;
        endcase
    endfunction

    task automatic handle(input int ev);
        int   g;
        int   act;
        exp_t e;
        if (sb.size() == 0 || sb[0].ev != ev) return;
        g = sb[0].grp;
        while (sb.size() > 0 && sb[0].ev == ev && sb[0].grp == g) begin
            e = sb.pop_front();
            act = actual(e.kind, e.a, e.b);
            applied++;
            if (act != e.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
            end
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin : monitor
        logic [3:0] prev;
        int seen;
        prev = 4'd0;
        seen = 0;
        forever begin
            @(posedge clk);
            #2;
            if (learning) begin
                if (prev != 4'd1) lcnt = 0;
                lcnt++;
            end
            if (decaying) begin
                if (prev != 4'd6) dcnt = 0;
                dcnt++;
            end
            if (dstate != prev) begin
                if (dstate == 4'd2) handle(EvLearnDone);
                if (dstate == 4'd5) handle(EvRecallDone);
                if (dstate == 4'd7) handle(EvDecayDone);
            end
            if (dstate == 4'd4) handle(EvRecallUpd);
            if (probe_cnt != seen) begin
                seen++;
                handle(EvProbe);
            end
            prev = dstate;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int st, input int lim, input string what);
        int k;
        k = 0;
        while (int'(dstate) != st && k < lim) begin
            @(negedge clk);
            k++;
        end
        applied++;
        if (int'(dstate) != st) begin
            miscompares++;
            $display("FAIL timeout %s: state %0d, expected %0d", what, dstate, st);
        end
    endtask

    task automatic probe();
        probe_cnt++;
        tick(1);
    endtask

    task automatic learn_event(input logic [5:0] p);
        pat = p;
        theta = 18'sd13107;
        wait_state(2, 40, "learn_done");
        theta = '0;
        wait_state(0, 10, "learn_idle");
        tick(1);
    endtask

    task automatic recall_event(input logic [5:0] cue);
        pat = cue;
        theta = -18'sd13107;
        wait_state(5, 80, "recall_done");
        theta = '0;
        wait_state(0, 10, "recall_idle");
        tick(1);
    endtask

    initial begin : stimulus
        tick(2);
        rst_n = 1'b1;
        new_group();
        expect_v(EvProbe, KState, 0, 0, 0, "reset_state");
        expect_v(EvProbe, KPp, 0, 0, 0, "reset_pp");
        expect_v(EvProbe, KFlags, 0, 0, 0, "reset_flags");
        expect_v(EvProbe, KW, 0, 1, 0, "reset_w01");
        probe();

        new_group();
        expect_v(EvLearnDone, KLcnt, 0, 0, 15, "learn_cycles");
        expect_v(EvLearnDone, KW, 0, 1, 2, "learn1_w01");
        expect_v(EvLearnDone, KW, 1, 0, 2, "learn1_w10");
        expect_v(EvLearnDone, KW, 0, 3, -2, "learn1_w03");
        expect_v(EvLearnDone, KW, 3, 4, 2, "learn1_w34");
        expect_v(EvLearnDone, KW, 0, 0, 0, "learn1_w00");
        learn_event(6'b000111);
        for (int k = 1; k < 10; k++) learn_event(6'b000111);

        new_group();
        expect_v(EvRecallUpd, KAcc, 0, 0, 60, "pass1_acc0");
        expect_v(EvRecallUpd, KAcc, 2, 0, 100, "pass1_acc2");
        expect_v(EvRecallUpd, KAcc, 3, 0, -60, "pass1_acc3");
        expect_v(EvRecallUpd, KFlags, 0, 0, 4, "pass1_flags");
        new_group();
        expect_v(EvRecallUpd, KPp, 0, 0, 7, "pass1_pp");
        expect_v(EvRecallUpd, KAcc, 0, 0, 100, "pass2_acc0");
        expect_v(EvRecallUpd, KAcc, 3, 0, -100, "pass2_acc3");
        new_group();
        expect_v(EvRecallDone, KPp, 0, 0, 7, "recall_pp");
        expect_v(EvRecallDone, KSettled, 0, 0, 1, "recall_settled");
        recall_event(6'b000011);

        for (int k = 10; k < 60; k++) learn_event(6'b000111);
        new_group();
        expect_v(EvProbe, KW, 0, 1, 100, "sat_w01");
        expect_v(EvProbe, KW, 0, 3, -100, "sat_w03");
        expect_v(EvProbe, KW, 2, 5, -100, "sat_w25");
        expect_v(EvProbe, KW, 4, 5, 100, "sat_w45");
        probe();

        new_group();
        expect_v(EvDecayDone, KDcnt, 0, 0, 15, "decay_cycles");
        expect_v(EvDecayDone, KW, 0, 1, 99, "decay_w01");
        expect_v(EvDecayDone, KW, 3, 0, -99, "decay_w30");
        expect_v(EvDecayDone, KW, 3, 4, 99, "decay_w34");
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            theta = 18'sd13107;
            tick(3);
            theta = -18'sd13107;
            tick(3);
        end
        theta = '0;
        wait_state(7, 40, "decay_done");
        wait_state(0, 10, "decay_idle");
        new_group();
        expect_v(EvProbe, KTrough, 0, 0, 0, "trough_cleared");
        expect_v(EvProbe, KW, 0, 1, 99, "one_decay_w01");
        expect_v(EvProbe, KW, 0, 3, -99, "one_decay_w03");
        probe();

        clk_en = 1'b0;
        pat = 6'b000111;
        theta = 18'sd13107;
        tick(3);
        new_group();
        expect_v(EvProbe, KState, 0, 0, 0, "clk_en_hold_state");
        expect_v(EvProbe, KW, 0, 1, 99, "clk_en_hold_w01");
        probe();
        theta = '0;
        clk_en = 1'b1;
        tick(2);

        pat = 6'b000011;
        theta = -18'sd13107;
        wait_state(3, 10, "clear_recall_start");
        tick(2);
        clear = 1'b1;
        new_group();
        expect_v(EvProbe, KState, 0, 0, 8, "clear_state");
        probe();
        clear = 1'b0;
        theta = '0;
        new_group();
        expect_v(EvProbe, KState, 0, 0, 0, "clear_to_idle");
        expect_v(EvProbe, KW, 0, 1, 0, "clear_w01");
        expect_v(EvProbe, KW, 0, 3, 0, "clear_w03");
        expect_v(EvProbe, KW, 3, 4, 0, "clear_w34");
        expect_v(EvProbe, KPp, 0, 0, 7, "clear_pp_held");
        probe();
        tick(2);

        pat = 6'b000111;
        theta = 18'sd13107;
        wait_state(1, 5, "reset_learn_start");
        tick(3);
        rst_n = 1'b0;
        new_group();
        expect_v(EvProbe, KState, 0, 0, 0, "rst_state");
        expect_v(EvProbe, KFlags, 0, 0, 0, "rst_flags");
        expect_v(EvProbe, KPp, 0, 0, 0, "rst_pp");
        expect_v(EvProbe, KW, 0, 1, 0, "rst_w01");
        expect_v(EvProbe, KW, 0, 3, 0, "rst_w03");
        expect_v(EvProbe, KAcc, 0, 0, 0, "rst_acc0");
        probe();
        theta = '0;
        rst_n = 1'b1;
        tick(4);

        applied++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/ca3_attractor_memory.md
CA3_ATTRACTOR_MEMORY -- requirements
Module: ca3_attractor_memory

Interface
REQ-001 Parameter WIDTH, default 18: theta sample width, signed.
REQ-002 Parameter FRAC, default 14: theta fractional bits.
REQ-003 Parameter N_UNITS, default 6: pattern bits; legal range 2..16.
REQ-004 Parameter WEIGHT_W, default 8: signed weight width.
REQ-005 Parameter LEARN_RATE, default 2: weight step per learn event.
REQ-006 Parameter WEIGHT_MAX, default 100: weight magnitude limit; must be below 2^(WEIGHT_W-1).
REQ-007 Parameter DECAY_RATE, default 1: weight magnitude decrement per decay event.
REQ-008 Parameter DECAY_INTERVAL, default 10: qualifying theta troughs per decay event.
REQ-009 Parameter RECALL_ITERS, default 4: maximum recall passes, range 1..15.
REQ-010 Parameter THETA_THR, default 12288: learn threshold +THETA_THR; recall threshold -THETA_THR.
REQ-011 Parameter THETA_HYST, default 4096: exit hysteresis.
REQ-012 clk  in  1  system clock; one clock; all state on rising edge.
REQ-013 rst_n  in  1  reset; asynchronous, active-low.
REQ-014 clk_en  in  1  advance enable; with clk_en=0, no state changes.
REQ-015 theta_x  in  WIDTH  signed theta phase reference.
REQ-016 pattern_in  in  N_UNITS  cue/training pattern; 1=in-phase, 0=anti-phase.
REQ-017 clear  in  1  synchronous weight wipe request, sampled when clk_en=1.
REQ-018 phase_pattern  out  N_UNITS  recalled attractor state.
REQ-019 learning, recalling, decaying  out  1 each  high while in the matching state group.
REQ-020 settled  out  1  last recall converged.
REQ-021 debug_state  out  4  current state encoding.

Function
REQ-022 Weights: N_UNITS x N_UNITS signed WEIGHT_W. Symmetric. Diagonal held at 0.
REQ-023 Bipolar mapping for all arithmetic: bit 1 -> +1, bit 0 -> -1.
REQ-024 States: IDLE, LEARN, LEARN_DONE, RECALL_ACC, RECALL_UPD, RECALL_DONE, DECAY, DECAY_DONE, CLEAR.
REQ-025 IDLE to LEARN: theta_x > +THETA_THR and pattern_in != 0.
REQ-026 IDLE to RECALL_ACC: theta_x < -THETA_THR and pattern_in != 0.
- On this entry, the recall state vector loads from pattern_in.
- Pass count clears.
REQ-027 Qualifying trough: pattern_in == 0 with a high-to-low theta edge. A theta_x > +THETA_THR sample arms the edge; arm value is 1 after reset.
- Each qualifying trough increments the trough counter.
REQ-028 IDLE to DECAY: counter >= DECAY_INTERVAL and theta_x < -THETA_THR.
REQ-029 LEARN: one cycle per pair i<j, N_UNITS*(N_UNITS-1)/2 cycles total.
- w_ij and w_ji both update by +LEARN_RATE*s_i*s_j.
- Result saturates at +/-WEIGHT_MAX.
REQ-030 LEARN_DONE: exit to IDLE when theta_x < THETA_THR - THETA_HYST.
REQ-031 RECALL_ACC: N_UNITS cycles. Column j per cycle: acc_i += w_ij*s_j for all i in parallel.
- acc width: WEIGHT_W + clog2(N_UNITS) + 1, signed, no overflow.
REQ-032 RECALL_UPD: single cycle. New s_i = 1 if acc_i > 0; 0 if acc_i < 0; unchanged if acc_i == 0.
- phase_pattern takes the new vector.
- acc clears.
REQ-033 RECALL_UPD exit conditions:
- New vector equals previous vector: settled=1, go to RECALL_DONE.
- Pass count reaches RECALL_ITERS: settled=0, go to RECALL_DONE.
- Otherwise: go to RECALL_ACC.
REQ-034 RECALL_DONE: exit to IDLE when theta_x > -THETA_THR + THETA_HYST.
REQ-035 DECAY: one cycle per pair i<j. Magnitude of w_ij and w_ji reduces by DECAY_RATE toward 0, clamped at 0 (sign never flips).
REQ-036 DECAY_DONE: exit on theta rise as REQ-034; the trough counter clears.
REQ-037 clear in any state: go to CLEAR. CLEAR zeroes all weights in one cycle, then IDLE.
- phase_pattern is held.
- clear has priority over every other transition.
REQ-038 pattern_in changing mid-LEARN: each pair uses the current sample.
REQ-039 Theta leaving the window mid-sequence does not abort LEARN, RECALL_ACC, RECALL_UPD or DECAY.

Reset
REQ-040 rst_n low: all weights, acc, recall vector, phase_pattern and counters go to 0.
- learning, recalling, decaying and settled go to 0.
- state goes to IDLE; edge arm goes to 1.
- Applies immediately, including mid-sequence.

Verification
REQ-041 Reset: assert rst_n=0 during LEARN -> all outputs 0, debug_state=IDLE, all weights 0.
REQ-042 Learn: N=6, pattern_in=6'b000111, theta_x=13107, one event.
- learning high 15 enabled cycles.
- w01=+2, w03=-2, w34=+2, w00=0.
REQ-043 Completion: after 10 learn events of 6'b000111, cue 6'b000011 at theta_x=-13107.
- Pass 1 acc0=60, acc2=100, acc3=-60; phase_pattern=6'b000111.
- Pass 2 identical; settled=1.
REQ-044 Saturation: 60 learn events of 6'b000111 -> w01=+100, w03=-100; no wrap.
REQ-045 Decay: from w01=+100, w03=-100, run 10 theta cycles with pattern_in=0.
- Exactly one decay: w01=+99, w03=-99.
- decaying high 15 cycles; counter cleared.
REQ-046 clear asserted on the 3rd RECALL_ACC cycle -> next cycle CLEAR, following cycle IDLE.
- All weights 0.
- phase_pattern unchanged.
